// File: rtl/msoc_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Round-robin with a bounded burst allowance; 1-cycle read return.
module msoc_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             owner;
  logic             init;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd_pend0;
  logic             rd_pend1;

  logic req0;
  logic req1;
  logic own_req;
  logic oth_req;
  logic own_ok;
  logic gnt0;
  logic gnt1;
  logic gnt_any;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign own_req = owner ? req1 : req0;
  assign oth_req = owner ? req0 : req1;

  // Owner resets to m1, yet m0 must win the first contested grant,
  // so the owner's allowance counts as spent until a grant is made.
  assign own_ok = own_req &
                  (~oth_req | (~init & (burst_cnt < CNT_MAX)));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (own_ok) begin
        gnt0 = ~owner;
        gnt1 = owner;
      end else if (oth_req) begin
        gnt0 = owner;
        gnt1 = ~owner;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b1;
      init      <= 1'b1;
      burst_cnt <= '0;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 & m0_read & ~m0_write;
      rd_pend1 <= gnt1 & m1_read & ~m1_write;
      if (gnt_any) begin
        init <= 1'b0;
        if (gnt1 == owner) begin
          if (burst_cnt != CNT_MAX)
            burst_cnt <= burst_cnt + CNT_ONE;
        end else begin
          owner     <= gnt1;
          burst_cnt <= CNT_ONE;
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  always_comb begin
    ram_chipselect = gnt_any;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    if (gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_write      = m0_write;
      ram_writedata  = m0_writedata;
    end else if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_write      = m1_write;
      ram_writedata  = m1_writedata;
    end
  end

  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdatavalid = rd_pend0;
  assign m1_readdatavalid = rd_pend1;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule
